// File: rtl/rf_pkg.sv
// Shared register-file definitions for decode, issue and writeback.
// Holds the default sizes, the address-width helper and the common typedefs.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    // Address width for a register file of nregs entries (never below one bit).
    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int RF_AW = rf_aw(RF_NREGS);

    typedef logic [RF_AW-1:0]   reg_addr_t;
    typedef logic [RF_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an outstanding producer.
// Flush beats issue, and issue beats a same-address writeback clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = RF_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_flush,
    input  logic                   i_issueEn,
    input  logic [AW-1:0]          i_issueAddr,
    input  logic                   i_wbEn,
    input  logic [AW-1:0]          i_wbAddr,
    input  logic [NRD-1:0][AW-1:0] i_rdAddr,
    output logic [NRD-1:0]         o_busy
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pendNext;

    // Next pending vector: clear the writeback target first so a same-address issue re-sets it.
    always_comb begin
        w_pendNext = r_pend;
        if (i_flush) begin
            w_pendNext = '0;
        end else begin
            if (i_wbEn && (i_wbAddr != '0)) begin
                w_pendNext[i_wbAddr] = 1'b0;
            end
            if (i_issueEn && (i_issueAddr != '0)) begin
                w_pendNext[i_issueAddr] = 1'b1;
            end
        end
    end

    // Pending-bit register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    // Per-port busy lookup; a writeback in this cycle already resolves the hazard.
    always_comb begin
        o_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            o_busy[p] = r_pend[i_rdAddr[p]]
                      & ~(i_wbEn && (i_wbAddr == i_rdAddr[p]))
                      & (i_rdAddr[p] != '0);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and pending-write scoreboard.
// Register 0 reads as zero; all outputs are held at zero while reset is asserted.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter  int XLEN  = RF_XLEN,
    parameter  int NREGS = RF_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    input  logic [NRD-1:0]           rd_use,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    output logic                     stall,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     flush
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NRD-1:0]  w_busy;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_issueEn   (issue_en),
        .i_issueAddr (issue_addr),
        .i_wbEn      (wb_en),
        .i_wbAddr    (wb_addr),
        .i_rdAddr    (rd_addr),
        .o_busy      (w_busy)
    );

    // Register storage: writes to x0 are dropped, reset wipes every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Read muxes with x0 forcing and writeback bypass, plus the combined stall request.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (reset_n) begin
                rd_busy[p] = w_busy[p];
                if (rd_addr[p] == '0) begin
                    rd_data[p] = '0;
                end else if (wb_en && (wb_addr == rd_addr[p])) begin
                    rd_data[p] = wb_data;
                end else begin
                    rd_data[p] = r_regs[rd_addr[p]];
                end
            end
        end
        stall = |(rd_use & rd_busy);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, RAW stall, x0, simultaneous events, flush.
module tb_regfile_scoreboard;
    import rf_pkg::*;

    logic                 clk;
    logic                 reset_n;
    logic [1:0][4:0]      rd_addr;
    logic [1:0]           rd_use;
    logic [1:0][31:0]     rd_data;
    logic [1:0]           rd_busy;
    logic                 stall;
    logic                 issue_en;
    logic [4:0]           issue_addr;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [31:0]          wb_data;
    logic                 flush;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_use     (rd_use),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .stall      (stall),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Move to the next cycle: just past the rising edge, then return all control inputs idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        issue_en = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd8;
        rd_use     = 2'b11;
        issue_en   = 1'b1;
        issue_addr = 5'd8;
        wb_en      = 1'b1;
        wb_addr    = 5'd5;
        wb_data    = 32'h55;
        flush      = 1'b0;

        // Held in reset across an edge with writeback and issue active: outputs stay zero.
        #12;
        checkOutput("reset_data_gated", rd_data[0], 0);
        checkOutput("reset_busy", rd_busy, 0);
        checkOutput("reset_stall", stall, 0);
        issue_en = 1'b0;
        wb_en    = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("reset_wb_ignored", rd_data[0], 0);
        checkOutput("reset_issue_ignored", rd_busy[1], 0);

        // Bypass of x7 in the writeback cycle, then from storage.
        applyStimulus();
        wb_en      = 1'b1;
        wb_addr    = 5'd7;
        wb_data    = 32'h12345678;
        rd_addr[0] = 5'd7;
        #1;
        checkOutput("bypass_same_cycle", rd_data[0], 32'h12345678);
        applyStimulus();
        #1;
        checkOutput("bypass_storage", rd_data[0], 32'h12345678);
        checkOutput("bypass_busy", rd_busy[0], 0);

        // RAW on x3: issue in cycle 0, writeback in cycle 4.
        applyStimulus();
        issue_en   = 1'b1;
        issue_addr = 5'd3;
        rd_addr[1] = 5'd3;
        rd_use     = 2'b10;
        #1;
        checkOutput("raw_c0_stall", stall, 0);
        checkOutput("raw_c0_busy", rd_busy[1], 0);
        applyStimulus();
        #1;
        checkOutput("raw_c1_stall", stall, 1);
        checkOutput("raw_c1_busy", rd_busy[1], 1);
        applyStimulus();
        rd_use = 2'b00;
        #1;
        checkOutput("raw_c2_unused_stall", stall, 0);
        checkOutput("raw_c2_busy", rd_busy[1], 1);
        applyStimulus();
        rd_use = 2'b10;
        #1;
        checkOutput("raw_c3_stall", stall, 1);
        applyStimulus();
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hA5;
        #1;
        checkOutput("raw_c4_stall", stall, 0);
        checkOutput("raw_c4_data", rd_data[1], 32'hA5);
        applyStimulus();
        #1;
        checkOutput("raw_c5_stall", stall, 0);
        checkOutput("raw_c5_data", rd_data[1], 32'hA5);

        // x0: issue and writeback to x0 are both discarded.
        applyStimulus();
        issue_en   = 1'b1;
        issue_addr = 5'd0;
        wb_en      = 1'b1;
        wb_addr    = 5'd0;
        wb_data    = 32'hFFFFFFFF;
        rd_addr[0] = 5'd0;
        rd_addr[1] = 5'd0;
        rd_use     = 2'b11;
        #1;
        checkOutput("x0_data0", rd_data[0], 0);
        checkOutput("x0_data1", rd_data[1], 0);
        checkOutput("x0_busy", rd_busy, 0);
        applyStimulus();
        #1;
        checkOutput("x0_after_data", rd_data, 0);
        checkOutput("x0_after_stall", stall, 0);

        // Issue x4, then issue and writeback x9 together.
        applyStimulus();
        issue_en   = 1'b1;
        issue_addr = 5'd4;
        applyStimulus();
        issue_en   = 1'b1;
        issue_addr = 5'd9;
        wb_en      = 1'b1;
        wb_addr    = 5'd9;
        wb_data    = 32'h1;
        rd_addr[0] = 5'd9;
        rd_addr[1] = 5'd4;
        #1;
        checkOutput("sim_bypass_data", rd_data[0], 32'h1);
        checkOutput("sim_same_cycle_busy9", rd_busy[0], 0);
        checkOutput("sim_busy4", rd_busy[1], 1);
        applyStimulus();
        #1;
        checkOutput("sim_next_data9", rd_data[0], 32'h1);
        checkOutput("sim_next_busy9", rd_busy[0], 1);

        // Flush cycle: issue to x10 ignored, writeback to x11 still lands.
        applyStimulus();
        flush      = 1'b1;
        issue_en   = 1'b1;
        issue_addr = 5'd10;
        wb_en      = 1'b1;
        wb_addr    = 5'd11;
        wb_data    = 32'hBB;
        #1;
        checkOutput("flush_cycle_busy", rd_busy, 2'b11);
        applyStimulus();
        #1;
        checkOutput("flush_busy_clear", rd_busy, 0);
        checkOutput("flush_data9", rd_data[0], 32'h1);
        checkOutput("flush_data4", rd_data[1], 0);
        rd_addr[0] = 5'd10;
        rd_addr[1] = 5'd11;
        #1;
        checkOutput("flush_issue_ignored", rd_busy[0], 0);
        checkOutput("flush_wb_written", rd_data[1], 32'hBB);

        // Issue x12 and writeback x9 together: both take effect.
        applyStimulus();
        issue_en   = 1'b1;
        issue_addr = 5'd12;
        wb_en      = 1'b1;
        wb_addr    = 5'd9;
        wb_data    = 32'h99;
        applyStimulus();
        rd_addr[0] = 5'd12;
        rd_addr[1] = 5'd9;
        #1;
        checkOutput("diff_issue_busy12", rd_busy[0], 1);
        checkOutput("diff_wb_data9", rd_data[1], 32'h99);
        checkOutput("diff_wb_busy9", rd_busy[1], 0);

        // Reset mid-run: write x5, issue x6, then pulse reset between edges.
        applyStimulus();
        wb_en      = 1'b1;
        wb_addr    = 5'd5;
        wb_data    = 32'hDEADBEEF;
        issue_en   = 1'b1;
        issue_addr = 5'd6;
        applyStimulus();
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd6;
        rd_use     = 2'b11;
        #1;
        checkOutput("pre_reset_x5", rd_data[0], 32'hDEADBEEF);
        checkOutput("pre_reset_busy6", rd_busy[1], 1);
        checkOutput("pre_reset_stall", stall, 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_data", rd_data[0], 0);
        checkOutput("mid_reset_busy", rd_busy, 0);
        checkOutput("mid_reset_stall", stall, 0);
        reset_n = 1'b1;
        applyStimulus();
        #1;
        checkOutput("post_reset_x5", rd_data[0], 0);
        checkOutput("post_reset_busy6", rd_busy[1], 0);
        rd_addr[0] = 5'd12;
        rd_addr[1] = 5'd7;
        #1;
        checkOutput("post_reset_busy12", rd_busy[0], 0);
        checkOutput("post_reset_x7", rd_data[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

- Parametrised integer register file with a write-through bypass and a per-register pending-write scoreboard for the pipelined RISC-V core.
- Decode reads operands through it; writeback writes results into it.
- The issue stage marks destination registers pending. The block reports per-port busy status and a combined stall request, so decode holds dependent instructions until their producers write back.
- Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers. Power of two, at least 2. AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1 to 4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- rd_addr  in  NRD×AW  read address, one per port.
- rd_use  in  NRD  port p is consumed this cycle; qualifies stall only.
- rd_data  out  NRD×XLEN  read data, one per port.
- rd_busy  out  NRD  register on port p has an outstanding write.
- stall  out  1  OR over p of (rd_use[p] & rd_busy[p]).
- issue_en  in  1  mark issue_addr pending.
- issue_addr  in  AW  destination register of the issuing instruction.
- wb_en  in  1  write wb_data to wb_addr and clear its pending bit.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  clear all pending bits; register data is untouched.

## Operation
Reset:
- reset_n low immediately clears all registers and all pending bits, independent of clk.
- While reset_n is low, rd_data = 0, rd_busy = 0 and stall = 0.
- issue_en, wb_en and flush are ignored during reset.

Reads (combinational):
- If rd_addr = 0: rd_data = 0.
- Else if wb_en and wb_addr = rd_addr: rd_data = wb_data (bypass).
- Otherwise: rd_data = the stored register.

Busy (combinational):
- rd_busy[p] = pend[rd_addr[p]] & ~(wb_en & wb_addr = rd_addr[p]).
- rd_busy[p] is always 0 for address 0.
- A same-cycle issue does not affect rd_busy; the pending bit only appears after the edge.

Write at the clock edge:
- If wb_en and wb_addr ≠ 0: regs[wb_addr] <= wb_data.
- Writes to address 0 are discarded.

Scoreboard update at the clock edge, in priority order:
- flush clears every pending bit. The same-cycle writeback data is still written. Issue is ignored in the flush cycle.
- Otherwise, if issue_en and issue_addr ≠ 0: pend[issue_addr] <= 1.
- Otherwise, if wb_en and wb_addr ≠ 0: pend[wb_addr] <= 0.
- issue_en and wb_en to the same address in the same cycle leaves the bit set (the new producer wins), while the data is still written.
- issue_en and wb_en to different addresses both take effect.

Other rules:
- One pending bit per register; the core guarantees at most one outstanding producer per register.
- Re-issuing to an already pending register leaves the bit set; this is not an error.
- Writeback to a non-pending register writes data normally and leaves the bit clear.
- Read ports are independent. Any number of ports may read the same address, including the address being written.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wb_en, wb_addr and wb_data.
- Write latency: data is visible through the bypass in the writeback cycle, and from storage from the next cycle.
- Pending latency: rd_busy rises the cycle after issue_en, and falls in the writeback cycle (through the bypass).
- stall is purely combinational; it has no registered path.
- Reset assertion is asynchronous. Deassertion is expected to be synchronised upstream.
- All state is cleared if reset_n is asserted mid-operation; no partial writes survive.

## Structure
- Package rf_pkg holds:
  - default XLEN and NREGS;
  - the AW derivation function;
  - typedefs reg_addr_t and reg_data_t, shared with decode and writeback.
- Sub-module rf_scoreboard holds:
  - the NREGS pending-bit vector;
  - the flush, issue and clear priority logic;
  - the busy lookup for each read port.
- regfile_scoreboard instantiates rf_scoreboard and owns the data array, the bypass muxes and stall.

## Test plan
- Reset mid-run: write x5 = 0xDEADBEEF and issue x6, then pulse reset_n low between edges. Required: rd_data = 0 and rd_busy = 0 immediately; x5 still reads 0 after reset.
- Bypass: wb_en, wb_addr = 7, wb_data = 0x12345678 with rd_addr[0] = 7 in the same cycle. Required: rd_data[0] = 0x12345678 that cycle and every later cycle.
- Scoreboard RAW:
  - issue x3 at cycle 0; rd_addr[1] = 3 with rd_use[1] = 1.
  - Required: stall = 0 in cycle 0, stall = 1 from cycle 1.
  - Writeback x3 = 0xA5 in cycle 4. Required: stall = 0 and rd_data[1] = 0xA5 in cycle 4.
- x0: issue_en and wb_en to x0 with wb_data = 0xFFFFFFFF. Required: all ports reading x0 return 0 with rd_busy = 0.
- Simultaneous events:
  - issue and writeback x9 (data 0x1) in the same cycle. Required: x9 reads 0x1 and rd_busy = 1 in the next cycle.
  - Then flush with x4 and x9 pending. Required: all busy bits clear next cycle, data unchanged.
